matrix_cell_scheduler: RTL and testbench

- Upstream sequencer for the column processor in the matrix coprocessor.
- Latches two flattened size x size matrices A and B on a start handshake.
- Issues every (i,j) pair to one column processor as row i of A and column j of B, in row-major order, and collects each returned cell into a flattened result matrix C.
- Signals completion with a done/ack handshake.

---
 rtl/matrix_cell_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_matrix_cell_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_cell_scheduler.sv
// Matrix cell scheduler: issues every (i,j) row/column pair to one column processor.
// Optional macro SCHED_TIMEOUT_EN adds a processor-response timeout with out_error.
module matrix_cell_scheduler #(
  parameter int size       = 4,
  parameter int cell_width = 8,
  parameter int width      = cell_width * size,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             in_clk,
  input  logic                             in_reset,
  input  logic                             in_start,
  input  logic [size*size*cell_width-1:0]  in_mat_a,
  input  logic [size*size*cell_width-1:0]  in_mat_b,
  output logic [width-1:0]                 out_row_a,
  output logic [width-1:0]                 out_col_b,
  output logic                             out_proc_ready,
  input  logic [width-1:0]                 in_proc_cell,
  input  logic                             in_proc_ready,
  output logic                             out_proc_ack,
  output logic [size*size*cell_width-1:0]  out_mat_c,
  output logic                             out_done,
  input  logic                             in_done_ack,
  output logic                             out_error
);

  localparam int MW = size * size * cell_width;
  localparam int IW = $clog2(size) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]    i, j, i_n, j_n;
  logic [MW-1:0]    a_q, b_q, c_q;
  logic [MW-1:0]    a_n, b_n, c_n;
  logic [width-1:0] row_q, col_q, row_n, col_n;
  logic [width-1:0] sel_row, sel_col;
  logic             rdy_q, rdy_n;
  logic             ack_q, ack_n;
  logic             done_q, done_n;
  logic             last_i, last_j;

  // Upper bits of the processor result are discarded on purpose.
  logic unused_cell_bits;
  assign unused_cell_bits = ^in_proc_cell[width-1:cell_width];

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt, tcnt_n;
  logic          err_q, err_n;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  assign last_i = (i == IW'(size - 1));
  assign last_j = (j == IW'(size - 1));

  // Select row i of latched A and column j of latched B.
  always_comb begin
    sel_row = '0;
    sel_col = '0;
    for (int k = 0; k < size; k++) begin
      sel_row[k*cell_width +: cell_width] =
        a_q[(int'(i)*size + k)*cell_width +: cell_width];
      sel_col[k*cell_width +: cell_width] =
        b_q[(k*size + int'(j))*cell_width +: cell_width];
    end
  end

  // Next-state and next-output logic of the sequencing FSM.
  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    a_n     = a_q;
    b_n     = b_q;
    c_n     = c_q;
    row_n   = row_q;
    col_n   = col_q;
    rdy_n   = rdy_q;
    ack_n   = ack_q;
    done_n  = done_q;
`ifdef SCHED_TIMEOUT_EN
    tcnt_n  = tcnt;
    err_n   = err_q;
`endif
    unique case (state)
      S_IDLE: begin
        row_n = '0;
        col_n = '0;
        rdy_n = 1'b0;
        ack_n = 1'b0;
        if (in_start) begin
          a_n     = in_mat_a;
          b_n     = in_mat_b;
          c_n     = '0;
          i_n     = '0;
          j_n     = '0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        row_n   = sel_row;
        col_n   = sel_col;
        rdy_n   = 1'b1;
`ifdef SCHED_TIMEOUT_EN
        tcnt_n  = '0;
`endif
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (in_proc_ready) begin
          c_n[(int'(i)*size + int'(j))*cell_width +: cell_width] =
            in_proc_cell[cell_width-1:0];
          rdy_n   = 1'b0;
          ack_n   = 1'b1;
          row_n   = '0;
          col_n   = '0;
          state_n = S_ACK;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          rdy_n   = 1'b0;
          row_n   = '0;
          col_n   = '0;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
`endif
      end
      S_ACK: begin
        if (!in_proc_ready) begin
          ack_n   = 1'b0;
          state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_i && last_j) begin
          done_n  = 1'b1;
          state_n = S_DONE;
        end else if (last_j) begin
          j_n     = '0;
          i_n     = i + IW'(1);
          state_n = S_ISSUE;
        end else begin
          j_n     = j + IW'(1);
          state_n = S_ISSUE;
        end
      end
      S_DONE: begin
        if (in_done_ack) begin
          done_n  = 1'b0;
`ifdef SCHED_TIMEOUT_EN
          err_n   = 1'b0;
`endif
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered-output storage with asynchronous reset.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state  <= S_IDLE;
      i      <= '0;
      j      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      rdy_q  <= 1'b0;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      tcnt   <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      i      <= i_n;
      j      <= j_n;
      a_q    <= a_n;
      b_q    <= b_n;
      c_q    <= c_n;
      row_q  <= row_n;
      col_q  <= col_n;
      rdy_q  <= rdy_n;
      ack_q  <= ack_n;
      done_q <= done_n;
`ifdef SCHED_TIMEOUT_EN
      tcnt   <= tcnt_n;
      err_q  <= err_n;
`endif
    end
  end

  assign out_row_a      = row_q;
  assign out_col_b      = col_q;
  assign out_proc_ready = rdy_q;
  assign out_proc_ack   = ack_q;
  assign out_mat_c      = c_q;
  assign out_done       = done_q;
`ifdef SCHED_TIMEOUT_EN
  assign out_error      = err_q;
`else
  assign out_error      = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_cell_scheduler.sv
// Directed bench for matrix_cell_scheduler (size 2, 8-bit cells).
// Includes a behavioural column processor with adjustable latency, ack hold and stall.
module tb_matrix_cell_scheduler;

  localparam int SZ = 2;
  localparam int CW = 8;
  localparam int W  = SZ * CW;
  localparam int MW = SZ * SZ * CW;
  localparam int TO = 16;

  logic          in_clk;
  logic          in_reset;
  logic          in_start;
  logic [MW-1:0] in_mat_a;
  logic [MW-1:0] in_mat_b;
  logic [W-1:0]  out_row_a;
  logic [W-1:0]  out_col_b;
  logic          out_proc_ready;
  logic [W-1:0]  in_proc_cell;
  logic          in_proc_ready;
  logic          out_proc_ack;
  logic [MW-1:0] out_mat_c;
  logic          out_done;
  logic          in_done_ack;
  logic          out_error;

  int n_checks = 0;
  int n_fail   = 0;
  int issue_n  = 0;
  int stall_at = -1;
  int lat      = 1;
  int hold     = 0;
  int overlap  = 0;
  logic [MW-1:0] exp_a = '0;
  logic [MW-1:0] exp_b = '0;

  matrix_cell_scheduler #(
    .size(SZ), .cell_width(CW), .width(W), .TIMEOUT(TO)
  ) dut (
    .in_clk(in_clk),
    .in_reset(in_reset),
    .in_start(in_start),
    .in_mat_a(in_mat_a),
    .in_mat_b(in_mat_b),
    .out_row_a(out_row_a),
    .out_col_b(out_col_b),
    .out_proc_ready(out_proc_ready),
    .in_proc_cell(in_proc_cell),
    .in_proc_ready(in_proc_ready),
    .out_proc_ack(out_proc_ack),
    .out_mat_c(out_mat_c),
    .out_done(out_done),
    .in_done_ack(in_done_ack),
    .out_error(out_error)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [MW-1:0] got,
                       input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] row_of(input logic [MW-1:0] m, input int r);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < SZ; k++) v[k*CW +: CW] = m[(r*SZ + k)*CW +: CW];
    return v;
  endfunction

  function automatic logic [W-1:0] col_of(input logic [MW-1:0] m, input int c);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < SZ; k++) v[k*CW +: CW] = m[(k*SZ + c)*CW +: CW];
    return v;
  endfunction

  function automatic logic [W-1:0] dot(input logic [W-1:0] r, input logic [W-1:0] c);
    int s;
    s = 0;
    for (int k = 0; k < SZ; k++) s += int'(r[k*CW +: CW]) * int'(c[k*CW +: CW]);
    return W'(s);
  endfunction

  // Ready and ack must never overlap.
  always @(negedge in_clk) if (out_proc_ready && out_proc_ack) overlap++;

  // Column processor model.
  initial begin : proc_model
    bit seen;
    int idx;
    int n;
    logic [W-1:0] sum;
    seen = 1'b0;
    in_proc_ready = 1'b0;
    in_proc_cell = '0;
    forever begin
      @(negedge in_clk);
      if (!out_proc_ready) seen = 1'b0;
      else if (!seen) begin
        seen = 1'b1;
        idx = issue_n;
        issue_n++;
        check("row_order", MW'(out_row_a), MW'(row_of(exp_a, idx / SZ)));
        check("col_order", MW'(out_col_b), MW'(col_of(exp_b, idx % SZ)));
        if (idx != stall_at) begin
          sum = dot(out_row_a, out_col_b);
          repeat (lat) @(negedge in_clk);
          in_proc_cell = sum;
          in_proc_ready = 1'b1;
          n = 0;
          while (!out_proc_ack && n < 50) begin
            @(negedge in_clk);
            n++;
          end
          if (n >= 50) check("ack_timeout", 0, 1);
          for (int h = 0; h < hold; h++) begin
            @(negedge in_clk);
            check("ack_hold", MW'(out_proc_ack), 1);
            check("no_reissue", MW'(out_proc_ready), 0);
          end
          in_proc_ready = 1'b0;
          in_proc_cell = '0;
        end
      end
    end
  end

  task automatic start_run(input logic [MW-1:0] a, input logic [MW-1:0] b);
    exp_a = a;
    exp_b = b;
    issue_n = 0;
    @(negedge in_clk);
    in_mat_a = a;
    in_mat_b = b;
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
    check("c_cleared", out_mat_c, 0);
  endtask

  task automatic run(input logic [MW-1:0] a, input logic [MW-1:0] b,
                     input logic [MW-1:0] c, input bit disturb,
                     input bit ack_start, input string tag);
    int n;
    start_run(a, b);
    if (disturb) begin
      repeat (3) @(negedge in_clk);
      in_mat_a = '1;
      in_mat_b = '0;
      in_start = 1'b1;
      @(negedge in_clk);
      in_start = 1'b0;
    end
    n = 0;
    while (!out_done && n < 500) begin
      @(negedge in_clk);
      n++;
    end
    check({tag, "_done"}, MW'(out_done), 1);
    check({tag, "_c"}, out_mat_c, c);
    check({tag, "_issues"}, issue_n, SZ * SZ);
    check({tag, "_err"}, MW'(out_error), 0);
    repeat (3) @(negedge in_clk);
    check({tag, "_done_hold"}, MW'(out_done), 1);
    check({tag, "_c_hold"}, out_mat_c, c);
    in_done_ack = 1'b1;
    in_start = ack_start;
    @(negedge in_clk);
    in_done_ack = 1'b0;
    in_start = 1'b0;
    check({tag, "_done_clr"}, MW'(out_done), 0);
    if (ack_start) begin
      repeat (5) @(negedge in_clk);
      check("start_with_ack", issue_n, SZ * SZ);
      check("idle_ready", MW'(out_proc_ready), 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    in_reset = 1'b1;
    in_start = 1'b0;
    in_mat_a = '0;
    in_mat_b = '0;
    in_done_ack = 1'b0;
    repeat (2) @(negedge in_clk);
    check("rst_c", out_mat_c, 0);
    check("rst_done", MW'(out_done), 0);
    check("rst_ready", MW'(out_proc_ready), 0);
    check("rst_ack", MW'(out_proc_ack), 0);
    check("rst_vec", MW'({out_row_a, out_col_b}), 0);
    check("rst_err", MW'(out_error), 0);
    in_reset = 1'b0;

    run(32'h04030201, 32'h08070605, 32'h322B1613, 1'b0, 1'b1, "basic");

    lat = 3;
    run(32'h10000010, 32'h10000010, 32'h00000000, 1'b0, 1'b0, "ovf");

    lat = 1;
    hold = 5;
    run(32'h03000102, 32'h04030201, 32'h0C090805, 1'b0, 1'b0, "hold");
    hold = 0;

    run(32'h04030201, 32'h08070605, 32'h322B1613, 1'b1, 1'b0, "ignore");

    stall_at = 2;
    start_run(32'h04030201, 32'h08070605);
    n = 0;
    while (issue_n < 3 && n < 100) begin
      @(negedge in_clk);
      n++;
    end
    check("stall_reached", issue_n, 3);
    check("partial_c", out_mat_c, 32'h00001613);
    #1 in_reset = 1'b1;
    #1;
    check("arst_ready", MW'(out_proc_ready), 0);
    check("arst_vec", MW'({out_row_a, out_col_b}), 0);
    check("arst_c", out_mat_c, 0);
    check("arst_ack_done", MW'({out_proc_ack, out_done}), 0);
    @(negedge in_clk);
    in_reset = 1'b0;
    stall_at = -1;
    run(32'h04030201, 32'h08070605, 32'h322B1613, 1'b0, 1'b0, "after_rst");

`ifdef SCHED_TIMEOUT_EN
    stall_at = 0;
    start_run(32'h04030201, 32'h08070605);
    n = 0;
    while (!out_done && n < 200) begin
      @(negedge in_clk);
      n++;
    end
    check("to_cycles", n, TO + 1);
    check("to_done", MW'(out_done), 1);
    check("to_err", MW'(out_error), 1);
    check("to_c", out_mat_c, 0);
    check("to_ready", MW'(out_proc_ready), 0);
    in_done_ack = 1'b1;
    @(negedge in_clk);
    in_done_ack = 1'b0;
    check("to_err_clr", MW'(out_error), 0);
    check("to_done_clr", MW'(out_done), 0);
    stall_at = -1;
`endif

    check("no_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
